// File: rtl/golden_nonce_if.sv
// Bus between the miner/host side and golden_nonce_fifo.
// The miner side drives the result; the host side drives wr_start/wr_clk and reads the frame byte.
interface golden_nonce_if;
   // Handshake: there is no valid/ready pair here. A nonzero golden_nonce that differs from
   // the previous cycle's value is a new record. A rising wr_start loads the next frame, and
   // every level change of wr_clk advances it by one byte. The host paces all transfers.
   logic [31:0] golden_nonce;
   logic [31:0] nonce2;
   logic [31:0] hash2;
   logic        wr_start;
   logic        wr_clk;
   logic [7:0]  write;
   logic [3:0]  fifo_level;
   logic        overflow;

   modport master (
      output golden_nonce, nonce2, hash2, wr_start, wr_clk,
      input  write, fifo_level, overflow
   );

   modport slave (
      input  golden_nonce, nonce2, hash2, wr_start, wr_clk,
      output write, fifo_level, overflow
   );
endinterface

// File: rtl/golden_nonce_fifo.sv
// Golden-nonce result queue. Each host read is serialised as one byte-wide frame.
// Optional macro GN_TIMESTAMP_EN appends a 32-bit capture timestamp to every record.
module golden_nonce_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   golden_nonce_if.slave  bus
);

`ifdef GN_TIMESTAMP_EN
   localparam int RW = 128;
`else
   localparam int RW = 96;
`endif
   localparam int FW = RW + 8;

   logic [RW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [31:0]   gn_last_q;
   logic          overflow_q, overflow_d;
   logic [7:0]    ovf_cnt_q, ovf_cnt_d;
   logic [2:0]    start_sync_q;
   logic [2:0]    wclk_sync_q;
   logic [FW-1:0] fr_q, fr_d;
`ifdef GN_TIMESTAMP_EN
   logic [31:0]   ts_q;
`endif

   logic          push, full, empty, load, shift, pop, accept, drop;
   logic [RW-1:0] record;
   logic [7:0]    status;

`ifdef GN_TIMESTAMP_EN
   assign record = {ts_q, bus.hash2, bus.nonce2, bus.golden_nonce};
`else
   assign record = {bus.hash2, bus.nonce2, bus.golden_nonce};
`endif

   // Sync bit 1 is s1 and bit 2 is s2. Both host strobes are decoded from these two stages.
   always_comb begin
      push   = (bus.golden_nonce != 32'd0) && (bus.golden_nonce != gn_last_q);
      full   = (level_q == (AW+1)'(DEPTH));
      empty  = (level_q == '0);
      load   = start_sync_q[1] & ~start_sync_q[2];
      shift  = wclk_sync_q[1] ^ wclk_sync_q[2];
      pop    = load & ~empty;
      accept = push & (~full | pop);
      drop   = push & full & ~pop;
      status = {~empty, overflow_q, 2'b00, 4'(level_q)};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // A frame load clears the drop history. A drop in that same cycle restarts it at one.
   always_comb begin
      ovf_cnt_d  = ovf_cnt_q;
      overflow_d = overflow_q;
      if (load) begin
         ovf_cnt_d  = drop ? 8'd1 : 8'd0;
         overflow_d = drop;
      end else if (drop) begin
         ovf_cnt_d  = (ovf_cnt_q == 8'hFF) ? 8'hFF : ovf_cnt_q + 8'd1;
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      fr_d = fr_q;
      if (load) begin
         if (empty) fr_d = {{RW{1'b0}}, status};
         else       fr_d = {mem_q[rd_ptr_q], status};
      end else if (shift) begin
         fr_d = {8'h00, fr_q[FW-1:8]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         gn_last_q    <= '0;
         overflow_q   <= 1'b0;
         ovf_cnt_q    <= '0;
         start_sync_q <= '0;
         wclk_sync_q  <= '0;
         fr_q         <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         gn_last_q    <= bus.golden_nonce;
         overflow_q   <= overflow_d;
         ovf_cnt_q    <= ovf_cnt_d;
         start_sync_q <= {start_sync_q[1:0], bus.wr_start};
         wclk_sync_q  <= {wclk_sync_q[1:0], bus.wr_clk};
         fr_q         <= fr_d;
      end
   end

`ifdef GN_TIMESTAMP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts_q <= '0;
      else          ts_q <= ts_q + 32'd1;
   end
`endif

   // Storage carries no reset. Only entries that the pointers cover are ever read.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= record;
   end

   assign bus.write      = fr_q[7:0];
   assign bus.fifo_level = 4'(level_q);
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Directed self-checking bench for golden_nonce_fifo (DEPTH=4). Expected frame bytes are queued
// from hand-computed values and compared one per wr_clk toggle.
module tb_golden_nonce_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  golden_nonce_if bus ();

  golden_nonce_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] single_bytes [12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                    8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] ovf_status [4] = '{8'hC4, 8'h83, 8'h82, 8'h81};
  logic [7:0] col_status [4] = '{8'h84, 8'h83, 8'h82, 8'h81};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_nonce(input logic [31:0] gn, input logic [31:0] n2, input logic [31:0] h2);
    bus.golden_nonce = gn;
    bus.nonce2       = n2;
    bus.hash2        = h2;
    tick(1);
  endtask

  task automatic idle_nonce();
    bus.golden_nonce = 32'd0;
    tick(1);
  endtask

  task automatic q_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic start_read(input string tag, input logic [7:0] exp_status);
    bus.wr_start = 1'b1;
    tick(3);
    check(tag, bus.write, exp_status);
    bus.wr_start = 1'b0;
  endtask

  task automatic drain_bytes(input string tag);
    logic [7:0] exp_b;
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      bus.wr_clk = ~bus.wr_clk;
      tick(3);
      check(tag, bus.write, exp_b);
    end
  endtask

  initial begin
    bus.golden_nonce = '0;
    bus.nonce2       = '0;
    bus.hash2        = '0;
    bus.wr_start     = 1'b0;
    bus.wr_clk       = 1'b0;

    // reset values while reset_n is low
    #1;
    check("rst_write", bus.write, 8'h00);
    check("rst_level", bus.fifo_level, 4'd0);
    check("rst_ovf", bus.overflow, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // single find
    push_nonce(32'h12345678, 32'hA5A5A5A5, 32'h00000001);
    idle_nonce();
    check("single_level", bus.fifo_level, 4'd1);
    start_read("single_status", 8'h81);
    for (int i = 0; i < 12; i++) exp_q.push_back(single_bytes[i]);
    drain_bytes("single_byte");
    check("single_level_after", bus.fifo_level, 4'd0);

    // empty read, including one shift past the end of the frame
    start_read("empty_status", 8'h00);
    for (int i = 0; i < 13; i++) exp_q.push_back(8'h00);
    drain_bytes("empty_byte");
    check("empty_level", bus.fifo_level, 4'd0);
    check("empty_ovf", bus.overflow, 1'b0);

    // overflow: six back-to-back finds into four entries
    for (int i = 1; i <= 6; i++) push_nonce(32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
    idle_nonce();
    check("ovf_level", bus.fifo_level, 4'd4);
    check("ovf_flag", bus.overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      start_read("ovf_status", ovf_status[k]);
      if (k == 0) check("ovf_cleared", bus.overflow, 1'b0);
      q_word(32'(k + 1));
      q_word(32'h100 + 32'(k + 1));
      drain_bytes("ovf_byte");
    end
    check("ovf_level_after", bus.fifo_level, 4'd0);

    // repeat and zero filter
    bus.golden_nonce = 32'hDEADBEEF;
    bus.nonce2 = 32'h0;
    bus.hash2 = 32'h0;
    tick(50);
    check("rep_level_hold", bus.fifo_level, 4'd1);
    bus.golden_nonce = 32'h0;
    tick(5);
    check("rep_level_zero", bus.fifo_level, 4'd1);
    push_nonce(32'hDEADBEEF, 32'h0, 32'h0);
    idle_nonce();
    check("rep_level_again", bus.fifo_level, 4'd2);
    start_read("rep_status0", 8'h82);
    q_word(32'hDEADBEEF);
    drain_bytes("rep_byte0");
    start_read("rep_status1", 8'h81);
    q_word(32'hDEADBEEF);
    drain_bytes("rep_byte1");
    check("rep_level_after", bus.fifo_level, 4'd0);

    // push at full in the same cycle as a frame load
    for (int i = 1; i <= 4; i++) push_nonce(32'h10 + 32'(i), 32'h310 + 32'(i), 32'h0);
    idle_nonce();
    check("col_level_full", bus.fifo_level, 4'd4);
    check("col_ovf_pre", bus.overflow, 1'b0);
    bus.wr_start = 1'b1;
    tick(2);
    bus.golden_nonce = 32'h15;
    bus.nonce2 = 32'h315;
    tick(1);
    bus.golden_nonce = 32'h0;
    bus.wr_start = 1'b0;
    check("col_status_first", bus.write, 8'h84);
    check("col_level", bus.fifo_level, 4'd4);
    check("col_ovf", bus.overflow, 1'b0);
    q_word(32'h11);
    q_word(32'h311);
    drain_bytes("col_byte_first");
    for (int k = 0; k < 4; k++) begin
      start_read("col_status", col_status[k]);
      q_word(32'h12 + 32'(k));
      q_word(32'h312 + 32'(k));
      drain_bytes("col_byte");
    end
    check("col_level_after", bus.fifo_level, 4'd0);

    // asynchronous reset with a loaded frame, a full queue and overflow set
    for (int i = 1; i <= 6; i++) push_nonce(32'h20 + 32'(i), 32'h0, 32'h0);
    idle_nonce();
    start_read("arst_status", 8'hC4);
    push_nonce(32'h27, 32'h0, 32'h0);
    push_nonce(32'h28, 32'h0, 32'h0);
    idle_nonce();
    check("arst_pre_level", bus.fifo_level, 4'd4);
    check("arst_pre_ovf", bus.overflow, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_write", bus.write, 8'h00);
    check("arst_level", bus.fifo_level, 4'd0);
    check("arst_ovf", bus.overflow, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(4);

    // recovery after reset
    push_nonce(32'h99, 32'h0, 32'h0);
    idle_nonce();
    check("recov_level", bus.fifo_level, 4'd1);
    start_read("recov_status", 8'h81);
    q_word(32'h99);
    drain_bytes("recov_byte");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
